// File: rtl/issue_controller_pkg.sv
//==============================================================================
// Module      : issue_pkg
// Description : Shared opcode constants, reservation-station class and
//               issue-state encodings, and the opcode classifier used by
//               issue_controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package issue_pkg;

  // Opcode field instr[15:13]
  localparam logic [2:0] OPC_ILL  = 3'b000;
  localparam logic [2:0] OPC_B    = 3'b001;
  localparam logic [2:0] OPC_BL   = 3'b010;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  typedef enum logic [1:0] {
    ALU = 2'b00,
    MEM = 2'b01,
    BR  = 2'b10
  } rs_class_t;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    BR_WAIT = 2'b01,
    HALTED  = 2'b10
  } issue_state_t;

  // HALT and illegal opcodes fall to ALU here; callers gate them separately,
  // which also makes the reset-state class read as 00.
  function automatic rs_class_t opc_class(input logic [2:0] opc);
    rs_class_t cls;
    case (opc)
      OPC_LDR, OPC_STR: cls = MEM;
      OPC_B,   OPC_BL:  cls = BR;
      default:          cls = ALU;
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_credit_counter.sv
//==============================================================================
// Module      : rs_credit_counter
// Description : Free-entry credit counter for one reservation-station class.
//               Starts full, decrements on take, increments on release,
//               saturates at DEPTH.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rs_credit_counter #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_take,
  input  logic                         i_release,
  output logic [$clog2(DEPTH+1)-1:0]   o_credits,
  output logic                         o_avail
);

  localparam int W = $clog2(DEPTH+1);
  localparam logic [W-1:0] c_full = W'(DEPTH);
  localparam logic [W-1:0] c_one  = W'(1);

  logic [W-1:0] r_credits;

  // Credit bookkeeping; a take and a release in the same cycle cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits <= c_full;
    end else if (i_take && !i_release) begin
      r_credits <= r_credits - c_one;
    end else if (i_release && !i_take && (r_credits != c_full)) begin
      r_credits <= r_credits + c_one;
    end
  end

  assign o_credits = r_credits;
  assign o_avail   = (r_credits != '0);

endmodule

`default_nettype wire

// File: rtl/issue_controller.sv
//==============================================================================
// Module      : issue_controller
// Description : Front-end issue sequencer. Holds one fetched instruction,
//               classifies it by opcode and issues it to the ALU, MEM or BR
//               reservation-station class under per-class credit control.
//               Fetch stalls on an unresolved branch and stops on HALT.
// Config      : ILLEGAL_TRAP_EN - opcode 000 sets a sticky illegal flag and
//               halts; otherwise opcode 000 is dropped as a NOP.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module issue_controller
  import issue_pkg::*;
#(
  parameter int RS_ALU_DEPTH = 4,
  parameter int RS_MEM_DEPTH = 2,
  parameter int RS_BR_DEPTH  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  output logic        if_ready,
  output logic        iss_valid,
  output logic [1:0]  iss_class,
  output logic [15:0] iss_instr,
  input  logic        rs_alu_release,
  input  logic        rs_mem_release,
  input  logic        rs_br_release,
  input  logic        br_resolve,
  output logic        halted,
  output logic        illegal
);

  issue_state_t r_state;
  issue_state_t w_state_nxt;
  logic [15:0]  r_instr_q;
  logic         r_q_valid;

  logic [2:0]   w_opc;
  rs_class_t    w_class;
  logic         w_is_halt;
  logic         w_is_ill;
  logic         w_avail;
  logic         w_run;
  logic         w_issue;
  logic         w_halt_cons;
  logic         w_ill_cons;
  logic         w_consume;
  logic         w_br_issue;
  logic         w_trap;
  logic         w_load;
  logic         w_alu_avail;
  logic         w_mem_avail;
  logic         w_br_avail;

  assign w_opc     = r_instr_q[15:13];
  assign w_class   = opc_class(w_opc);
  assign w_is_halt = (w_opc == OPC_HALT);
  assign w_is_ill  = (w_opc == OPC_ILL);
  assign w_run     = (r_state == RUN);

  // Credit availability for the class of the held instruction
  always_comb begin
    w_avail = 1'b0;
    case (w_class)
      ALU:     w_avail = w_alu_avail;
      MEM:     w_avail = w_mem_avail;
      BR:      w_avail = w_br_avail;
      default: w_avail = 1'b0;
    endcase
  end

  assign w_issue     = w_run && r_q_valid && !w_is_halt && !w_is_ill && w_avail;
  assign w_halt_cons = w_run && r_q_valid && w_is_halt;
  assign w_ill_cons  = w_run && r_q_valid && w_is_ill;
  assign w_consume   = w_issue || w_halt_cons || w_ill_cons;
  assign w_br_issue  = w_issue && (w_class == BR);

  // Fetch must not slip past a branch that is issuing this cycle
  assign if_ready = rst_n && w_run && (!r_q_valid || w_consume) && !w_br_issue;
  assign w_load   = if_valid && if_ready;

`ifdef ILLEGAL_TRAP_EN
  assign w_trap = w_ill_cons;

  logic r_illegal;

  // Sticky illegal-opcode flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_ill_cons) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
`else
  assign w_trap  = 1'b0;
  assign illegal = 1'b0;
`endif

  // Single-entry instruction register; a reload wins over a consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_q <= '0;
      r_q_valid <= 1'b0;
    end else if (w_load) begin
      r_instr_q <= if_instr;
      r_q_valid <= 1'b1;
    end else if (w_consume) begin
      r_q_valid <= 1'b0;
    end
  end

  // Issue state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: branch wait, HALT, and optional illegal trap
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_br_issue) begin
          w_state_nxt = BR_WAIT;
        end else if (w_halt_cons || w_trap) begin
          w_state_nxt = HALTED;
        end
      end
      BR_WAIT: begin
        if (br_resolve) begin
          w_state_nxt = RUN;
        end
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  rs_credit_counter #(.DEPTH(RS_ALU_DEPTH)) u_cred_alu (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_take    (w_issue && (w_class == ALU)),
    .i_release (rs_alu_release),
    .o_credits (),
    .o_avail   (w_alu_avail)
  );

  rs_credit_counter #(.DEPTH(RS_MEM_DEPTH)) u_cred_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_take    (w_issue && (w_class == MEM)),
    .i_release (rs_mem_release),
    .o_credits (),
    .o_avail   (w_mem_avail)
  );

  rs_credit_counter #(.DEPTH(RS_BR_DEPTH)) u_cred_br (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_take    (w_br_issue),
    .i_release (rs_br_release),
    .o_credits (),
    .o_avail   (w_br_avail)
  );

  assign iss_valid = w_issue;
  assign iss_class = w_class;
  assign iss_instr = r_instr_q;
  assign halted    = (r_state == HALTED);

endmodule

`default_nettype wire

// File: tb/tb_issue_controller.sv
//==============================================================================
// Module      : tb_issue_controller
// Description : Self-checking bench for issue_controller. Accepted
//               instructions push their expected issue into a scoreboard;
//               a negedge monitor pops and compares every issue and checks
//               handshake/credit/halt behaviour against a reference model.
// Config      : ILLEGAL_TRAP_EN selects the expected opcode-000 behaviour.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_issue_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_valid = 1'b0;
  logic [15:0] if_instr = 16'h0;
  logic        if_ready;
  logic        iss_valid;
  logic [1:0]  iss_class;
  logic [15:0] iss_instr;
  logic        rs_alu_release = 1'b0;
  logic        rs_mem_release = 1'b0;
  logic        rs_br_release = 1'b0;
  logic        br_resolve = 1'b0;
  logic        halted;
  logic        illegal;

  int checks = 0;
  int failures = 0;
  int issued = 0;

  always #5 clk = ~clk;

  issue_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .iss_valid      (iss_valid),
    .iss_class      (iss_class),
    .iss_instr      (iss_instr),
    .rs_alu_release (rs_alu_release),
    .rs_mem_release (rs_mem_release),
    .rs_br_release  (rs_br_release),
    .br_resolve     (br_resolve),
    .halted         (halted),
    .illegal        (illegal)
  );

  // ---------------- reference model ----------------
  // mode: 0 running, 1 waiting for branch, 2 halted
  int          m_mode;
  bit          m_full;
  logic [15:0] m_instr;
  int          m_cred[3];
  bit          m_ill;
  bit          m_acc;
  int          depth[3] = '{4, 2, 1};
  logic [17:0] sb[$];

  int e_cls;
  bit e_issue, e_drop, e_rdy;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // -1 means "never issued" (HALT or opcode 000)
  function automatic int cls_of(input logic [15:0] ins);
    logic [2:0] op;
    op = ins[15:13];
    if (op == 3'd5 || op == 3'd6) return 0;
    if (op == 3'd3 || op == 3'd4) return 1;
    if (op == 3'd1 || op == 3'd2) return 2;
    return -1;
  endfunction

  task automatic eval();
    e_cls   = cls_of(m_instr);
    e_issue = 1'b0;
    if (m_mode == 0 && m_full && e_cls >= 0) e_issue = (m_cred[e_cls] > 0);
    e_drop  = (m_mode == 0) && m_full && (e_cls < 0);
    e_rdy   = (m_mode == 0) && (!m_full || e_issue || e_drop) && !(e_issue && e_cls == 2);
  endtask

  task automatic model_reset();
    m_mode = 0; m_full = 1'b0; m_instr = 16'h0; m_ill = 1'b0; m_acc = 1'b0;
    for (int c = 0; c < 3; c++) m_cred[c] = depth[c];
    sb.delete();
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model at each active edge from the inputs the DUT sees
  always @(posedge clk) begin
    if (rst_n) begin
      bit rel[3];
      int old_mode;
      eval();
      rel[0] = rs_alu_release; rel[1] = rs_mem_release; rel[2] = rs_br_release;
      for (int c = 0; c < 3; c++) begin
        bit tk;
        tk = e_issue && (e_cls == c);
        if (tk && !rel[c]) m_cred[c]--;
        else if (rel[c] && !tk && m_cred[c] < depth[c]) m_cred[c]++;
      end
      old_mode = m_mode;
      if (m_mode == 0) begin
        if (e_issue && e_cls == 2) m_mode = 1;
        else if (m_full && m_instr[15:13] == 3'b111) m_mode = 2;
        else if (m_full && m_instr[15:13] == 3'b000 && TRAP) begin
          m_mode = 2; m_ill = 1'b1;
        end
      end else if (m_mode == 1 && br_resolve) begin
        m_mode = 0;
      end
      m_acc = if_valid && e_rdy;
      if (m_acc) begin
        if (cls_of(if_instr) >= 0) sb.push_back({2'(cls_of(if_instr)), if_instr});
        m_full = 1'b1; m_instr = if_instr;
      end else if (e_issue || e_drop) begin
        m_full = 1'b0;
      end
      // anything still queued when the controller freezes can never issue
      if (m_mode == 2 && old_mode != 2) sb.delete();
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      eval();
      chk("if_ready",  if_ready,  e_rdy);
      chk("iss_valid", iss_valid, e_issue);
      chk("halted",    halted,    m_mode == 2);
      chk("illegal",   illegal,   m_ill);
      chk("cred_alu",  dut.u_cred_alu.o_credits, m_cred[0]);
      chk("cred_mem",  dut.u_cred_mem.o_credits, m_cred[1]);
      chk("cred_br",   dut.u_cred_br.o_credits,  m_cred[2]);
      if (iss_valid) begin
        issued++;
        if (sb.size() == 0) begin
          chk("unexpected_issue", iss_instr, 16'hFFFF + 32'h1);
        end else begin
          logic [17:0] e;
          e = sb.pop_front();
          chk("iss_class", iss_class, e[17:16]);
          chk("iss_instr", iss_instr, e[15:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] ins);
    if_valid = 1'b1;
    if_instr = ins;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (m_acc) return;
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    if_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_alu(input int n);
    rs_alu_release = 1'b1;
    repeat (n) tick();
    rs_alu_release = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_valid = 1'b0; br_resolve = 1'b0;
    rs_alu_release = 1'b0; rs_mem_release = 1'b0; rs_br_release = 1'b0;
    #1;
    chk("rst_if_ready",  if_ready,  0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_class", iss_class, 0);
    chk("rst_iss_instr", iss_instr, 0);
    chk("rst_halted",    halted,    0);
    chk("rst_illegal",   illegal,   0);
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [2:0] op;
    logic [12:0] lo;
    case ($urandom_range(0, 9))
      0, 1, 2: op = 3'b101;
      3:       op = 3'b110;
      4, 5:    op = 3'b011;
      6:       op = 3'b100;
      7:       op = 3'b001;
      8:       op = 3'b010;
      default: op = 3'b101;
    endcase
    lo = 13'($urandom);
    return {op, lo};
  endfunction

  initial begin
    #2;
    do_reset();

    // back-to-back ADDs
    send(16'hA000); send(16'hA121); send(16'hA242);
    idle(3);

    // credit exhaustion and single release
    pulse_alu(3);
    for (int i = 0; i < 5; i++) send(16'hA300 + 16'(i));
    idle(3);
    pulse_alu(1);
    idle(2);
    pulse_alu(5);

    // branch stall; resolve in the issue cycle is ignored
    send(16'h2004);
    if_valid = 1'b1; if_instr = 16'hA555;
    br_resolve = 1'b1; tick(); br_resolve = 1'b0;
    tick(); tick();
    br_resolve = 1'b1; tick(); br_resolve = 1'b0;
    send(16'hA555);
    idle(2);

    // simultaneous issue and release, release at full
    send(16'h6000);
    rs_mem_release = 1'b1; tick(); rs_mem_release = 1'b0;
    rs_br_release = 1'b1; tick(); tick(); rs_br_release = 1'b0;
    idle(2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (!if_valid || m_acc) begin
        if ($urandom_range(0, 99) < 70) begin
          if_valid = 1'b1; if_instr = rand_instr();
        end else begin
          if_valid = 1'b0;
        end
      end
      rs_alu_release = ($urandom_range(0, 99) < 30);
      rs_mem_release = ($urandom_range(0, 99) < 25);
      rs_br_release  = ($urandom_range(0, 99) < 25);
      br_resolve     = ($urandom_range(0, 99) < 20);
      tick();
    end
    rs_alu_release = 1'b0; rs_mem_release = 1'b0;
    rs_br_release = 1'b0; br_resolve = 1'b0;

    // reset with traffic in flight
    if_valid = 1'b1; if_instr = 16'hA0F0;
    do_reset();

    // opcode 000 followed by an ADD
    send(16'h0000); send(16'hA777);
    idle(4);
    do_reset();

    // HALT freezes the controller
    send(16'hE000);
    idle(10);
    do_reset();

    send(16'hA001); send(16'h6123);
    idle(3);

    chk("sb_empty", sb.size(), 0);
    chk("issued_some", issued > 20, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
